wb_ram_burst_ctrl: RTL and testbench
====================================

# wb_ram_burst_ctrl

Wishbone B4 slave front-end for the 32-bit generic byte-enabled RAM. It converts classic and registered-feedback burst cycles (CTI/BTE) into RAM write strobes and read/write word addresses. Reads use the RAM's one-cycle registered read path. During bursts it pre-computes the next beat address so the RAM streams one word per clock.

## Interface
- `depth`, 256, RAM size in 32-bit words; power of two, at least 16.
- `aw`, 32, Wishbone byte-address width.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, synchronous and active-high.
- `wb_adr_i` in aw: byte address. Word address `wa` = `wb_adr_i[$clog2(depth)+1:2]`.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte selects.
- `wb_we_i` in 1: write enable.
- `wb_cti_i` in 3: cycle type. 000 classic, 001 constant, 010 incrementing, 111 end-of-burst; 011–110 treated as 000.
- `wb_bte_i` in 2: burst type. 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `wb_cyc_i`, `wb_stb_i` in 1: bus cycle and strobe.
- `wb_ack_o` out 1: normal termination.
- `wb_err_o` out 1: error termination.
- `wb_dat_o` out 32: read data, wired directly from `ram_dout`.
- `ram_we` out 4: byte write strobes.
- `ram_din` out 32: equals `wb_dat_i`.
- `ram_waddr`, `ram_raddr` out $clog2(depth): word addresses.
- `ram_dout` in 32: registered RAM read data, valid one cycle after `ram_raddr`.

## Operation
- `valid` = `wb_cyc_i & wb_stb_i`.
- `burst` = `wb_cti_i` is 001 or 010. `oor` = `wb_adr_i` ≥ 4·depth.
- Registers: `adr_r` (word), `ack_r`, `err_r`. Outputs: `wb_ack_o` = `ack_r`, `wb_err_o` = `err_r`.
- Address path:
  - `ram_raddr` = `next(adr_r)` when `ack_r & valid & burst`; otherwise `wa`.
  - `adr_r <= ram_raddr` every cycle.
  - `ram_waddr` = `adr_r`.
- `next(a)` per `wb_cti_i`/`wb_bte_i`:
  - constant: `a`.
  - linear: `a+1` mod depth.
  - wrap-N: upper bits of `a` kept, low log2(N) bits incremented mod N.
- Ack/err generation:
  - `ack_r <= valid & ~oor & (~ack_r | (burst & ~err_r))`.
  - `err_r <= valid & oor & ~err_r & ~ack_r`.
  - Classic and 111 beats therefore produce single-cycle ack pulses. Bursts ack every cycle after the first.
- Write: `ram_we` = `wb_sel_i` when `ack_r & valid & wb_we_i`, else 0.
  - The write occurs in the ack cycle, at `adr_r`, with the data the master presents for that beat.
  - No write is ever issued on an err cycle.
- Read: `wb_dat_o` in the ack cycle is the word at `adr_r`.
- End of burst: the beat carrying cti=111 is acked, then `ack_r` drops for one cycle. A new cycle may restart on the following clock.
- Master drops `cyc` or `stb` mid-burst: `ack_r` clears on the next edge. `ram_we` is zero immediately, since it is gated by `valid`.
- Reset, including mid-burst:
  - `adr_r`=0, `ack_r`=0, `err_r`=0; `ram_we`=0 in the reset cycle.
  - The first request after reset is treated as a new first beat.
- `oor` is evaluated on each beat's presented address. An in-burst beat that crosses out of range terminates with err instead of ack.

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `ram_we`=0. `ram_raddr`=`wa`; `ram_waddr`=0.
- Classic read/write: `valid` sampled at edge N; ack high during cycle N+1 only; latency 1. Back-to-back classic cycles give at most one ack every 2 cycles.
- Burst of L beats: acks in cycles N+1..N+L, one per clock, no wait states.
- Error: `wb_err_o` high for one cycle, one cycle after `valid`. `ram_we` stays 0.
- `ack_r` and `err_r` are never high in the same cycle.

## Test plan
- Classic write with sel=4'b0101 of 0xAABBCCDD to byte address 0x10 over a word holding 0x11223344, then classic read of 0x10:
  - write acks 1 cycle after stb;
  - read returns 0x11BB33DD, ack 1 cycle after stb.
- Incrementing linear read burst of 4 from word 254, depth=256, words preloaded with their index:
  - acks on 4 consecutive cycles;
  - data 254, 255, 0, 1;
  - ack low the cycle after the cti=111 beat.
- Wrap-4 write burst starting at word 6, data 0xA0..0xA3, then read back:
  - words 6, 7, 4, 5 hold 0xA0, 0xA1, 0xA2, 0xA3.
- Wrap-8 and wrap-16 read bursts starting at words 13 and 30, 8 and 16 beats:
  - address sequences wrap at 8- and 16-word boundaries, one ack per clock.
- Classic access to byte address 4·depth:
  - `wb_err_o` pulses 1 cycle later;
  - no ack; `ram_we` stays 0; memory unchanged.
- Reset asserted on beat 2 of an 8-beat write burst:
  - ack is 0 on the next cycle;
  - only beats 0–1 are written;
  - a classic read issued right after reset deasserts acks after 1 cycle with correct data.

Source files
------------

// File: rtl/wb_ram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// wb_ram_burst_ctrl
//
// Wishbone B4 slave front-end for a 32-bit byte-enabled RAM with a one-cycle
// registered read path. Classic cycles are acked one cycle after the request.
// Registered-feedback bursts (CTI 001/010, BTE linear/wrap-4/8/16) are acked
// on every clock: while a burst beat is being acked, the read address already
// points at the next beat, so the RAM delivers the next word on the following
// clock.
//
// Parameters
//   depth : RAM size in 32-bit words (power of two, >= 16)
//   aw    : Wishbone byte-address width
//
// Ports
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wb_adr_i           : byte address (word address = wb_adr_i[log2(depth)+1:2])
//   wb_dat_i, wb_sel_i : write data and byte selects
//   wb_we_i            : write enable
//   wb_cti_i, wb_bte_i : cycle type / burst type
//   wb_cyc_i, wb_stb_i : bus cycle and strobe
//   wb_ack_o, wb_err_o : registered normal / error termination
//   wb_dat_o           : read data, straight from ram_dout
//   ram_we             : RAM byte write strobes
//   ram_din            : RAM write data (wb_dat_i)
//   ram_waddr          : RAM write word address (registered beat address)
//   ram_raddr          : RAM read word address
//   ram_dout           : RAM registered read data
// -----------------------------------------------------------------------------
module wb_ram_burst_ctrl #(
  parameter int depth = 256,
  parameter int aw    = 32
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [aw-1:0]            wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic [2:0]               wb_cti_i,
  input  logic [1:0]               wb_bte_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [31:0]              wb_dat_o,
  output logic [3:0]               ram_we,
  output logic [31:0]              ram_din,
  output logic [$clog2(depth)-1:0] ram_waddr,
  output logic [$clog2(depth)-1:0] ram_raddr,
  input  logic [31:0]              ram_dout
);

  localparam int wa_w = $clog2(depth);

  logic            valid_s;
  logic            burst_s;
  logic            oor_s;
  logic            use_next_s;
  logic [wa_w-1:0] wa_s;
  logic [wa_w-1:0] next_adr_s;
  logic [wa_w-1:0] adr_r;
  logic            ack_r;
  logic            err_r;

  // Address of the beat following 'a' for the given cycle/burst type.
  // Wrap bursts keep the upper bits and roll the low log2(N) bits.
  function automatic logic [wa_w-1:0] next_adr(
    input logic [wa_w-1:0] a,
    input logic [2:0]      cti,
    input logic [1:0]      bte
  );
    logic [wa_w-1:0] n;
    n = a;
    case (cti)
      3'b001: n = a;
      3'b010: begin
        case (bte)
          2'b00:   n = a + {{(wa_w-1){1'b0}}, 1'b1};
          2'b01:   n = {a[wa_w-1:2], a[1:0] + 2'd1};
          2'b10:   n = {a[wa_w-1:3], a[2:0] + 3'd1};
          2'b11:   n = {a[wa_w-1:4], a[3:0] + 4'd1};
          default: n = a;
        endcase
      end
      default: n = a;
    endcase
    return n;
  endfunction

  assign valid_s    = wb_cyc_i & wb_stb_i;
  assign burst_s    = (wb_cti_i == 3'b001) | (wb_cti_i == 3'b010);
  // Any address bit above the RAM's byte range set means out of range.
  assign oor_s      = (wb_adr_i >> (wa_w + 2)) != {aw{1'b0}};
  assign wa_s       = wb_adr_i[wa_w+1:2];
  assign next_adr_s = next_adr(adr_r, wb_cti_i, wb_bte_i);
  // Only look ahead while a burst beat is actually being acked; reset forces
  // the plain presented address so a restarted cycle is a fresh first beat.
  assign use_next_s = ack_r & valid_s & burst_s & ~wb_rst_i;

  // Read address selection and byte write strobes.
  always_comb begin
    ram_raddr = wa_s;
    ram_we    = 4'b0000;
    if (use_next_s) begin
      ram_raddr = next_adr_s;
    end else begin
      ram_raddr = wa_s;
    end
    // ack_r and err_r are exclusive, so gating on ack_r also blocks writes
    // on error terminations.
    if (ack_r & valid_s & wb_we_i & ~wb_rst_i) begin
      ram_we = wb_sel_i;
    end else begin
      ram_we = 4'b0000;
    end
  end

  // Beat address register and termination flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_r <= {wa_w{1'b0}};
      ack_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      adr_r <= ram_raddr;
      // A classic beat acks once then drops for a cycle; a burst keeps
      // acking as long as the master keeps the burst going.
      ack_r <= valid_s & ~oor_s & (~ack_r | (burst_s & ~err_r));
      err_r <= valid_s & oor_s & ~err_r & ~ack_r;
    end
  end

  assign wb_ack_o  = ack_r;
  assign wb_err_o  = err_r;
  assign wb_dat_o  = ram_dout;
  assign ram_din   = wb_dat_i;
  assign ram_waddr = adr_r;

endmodule

// File: tb/tb_wb_ram_burst_ctrl.sv
module tb_wb_ram_burst_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic [31:0] dat_o;
  logic [3:0]  ram_we;
  logic [31:0] ram_din;
  logic [7:0]  ram_waddr;
  logic [7:0]  ram_raddr;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:255];
  logic        preload;

  int checks;
  int errors;

  logic [7:0]  seq_v [0:15];
  logic [31:0] dat_v [0:15];

  wb_ram_burst_ctrl #(.depth(256), .aw(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_dat_o (dat_o),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-enabled RAM with a registered read port (old data on collision).
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= mem[ram_raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  // Single classic cycle; expects ack exactly one cycle after the request.
  task automatic classic(input logic [31:0] badr, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = badr; we = w; sel = s; dat_i = d;
    cti = 3'b000; bte = 2'b00;
    @(negedge clk);
    check_eq({tag, " ack0"}, {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, " ack1"}, {31'd0, ack}, 32'd1);
    if (w) begin
      check_eq({tag, " we"}, {28'd0, ram_we}, {28'd0, s});
      check_eq({tag, " waddr"}, {24'd0, ram_waddr}, {24'd0, badr[9:2]});
    end else begin
      check_eq({tag, " rdata"}, dat_o, exp_rd);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check_eq({tag, " ackoff"}, {31'd0, ack}, 32'd0);
  endtask

  // Incrementing burst driven from seq_v/dat_v; dat_v is write data or expected read data.
  task automatic run_burst(input int len, input logic [1:0] b, input logic w, input string tag);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; bte = b;
    adr = {22'd0, seq_v[0], 2'b00}; dat_i = dat_v[0];
    cti = (len == 1) ? 3'b111 : 3'b010;
    @(negedge clk);
    check_eq({tag, " first ack0"}, {31'd0, ack}, 32'd0);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      adr = {22'd0, seq_v[k], 2'b00}; dat_i = dat_v[k];
      cti = (k == len - 1) ? 3'b111 : 3'b010;
      @(negedge clk);
      check_eq($sformatf("%s ack b%0d", tag, k), {31'd0, ack}, 32'd1);
      if (w) begin
        check_eq($sformatf("%s we b%0d", tag, k), {28'd0, ram_we}, 32'h0000000F);
        check_eq($sformatf("%s waddr b%0d", tag, k), {24'd0, ram_waddr}, {24'd0, seq_v[k]});
      end else begin
        check_eq($sformatf("%s data b%0d", tag, k), dat_o, dat_v[k]);
      end
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check_eq({tag, " ack after end"}, {31'd0, ack}, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; preload = 1'b1;
    adr = 32'h0000_0044; dat_i = 32'd0; sel = 4'h0;
    idle();
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    @(negedge clk);
    check_eq("rst ack", {31'd0, ack}, 32'd0);
    check_eq("rst err", {31'd0, err}, 32'd0);
    check_eq("rst we", {28'd0, ram_we}, 32'd0);
    check_eq("rst waddr", {24'd0, ram_waddr}, 32'd0);
    check_eq("rst raddr", {24'd0, ram_raddr}, 32'h11);
    @(posedge clk); #1;
    idle();
    rst = 1'b0; preload = 1'b0;

    // Classic write / partial write / read of word 4.
    classic(32'h10, 1'b1, 4'hF, 32'h11223344, 32'd0, "cw full");
    classic(32'h10, 1'b1, 4'b0101, 32'hAABBCCDD, 32'd0, "cw sel");
    classic(32'h10, 1'b0, 4'hF, 32'd0, 32'h11BB33DD, "cr merge");

    // Linear incrementing read crossing the top of memory.
    seq_v[0] = 8'd254; seq_v[1] = 8'd255; seq_v[2] = 8'd0; seq_v[3] = 8'd1;
    dat_v[0] = 32'd254; dat_v[1] = 32'd255; dat_v[2] = 32'd0; dat_v[3] = 32'd1;
    run_burst(4, 2'b00, 1'b0, "lin rd");

    // Wrap-4 write from word 6, then classic read back.
    seq_v[0] = 8'd6; seq_v[1] = 8'd7; seq_v[2] = 8'd4; seq_v[3] = 8'd5;
    dat_v[0] = 32'hA0; dat_v[1] = 32'hA1; dat_v[2] = 32'hA2; dat_v[3] = 32'hA3;
    run_burst(4, 2'b01, 1'b1, "wrap4 wr");
    classic(32'd24, 1'b0, 4'hF, 32'd0, 32'hA0, "rb w6");
    classic(32'd28, 1'b0, 4'hF, 32'd0, 32'hA1, "rb w7");
    classic(32'd16, 1'b0, 4'hF, 32'd0, 32'hA2, "rb w4");
    classic(32'd20, 1'b0, 4'hF, 32'd0, 32'hA3, "rb w5");

    // Wrap-8 read from word 13: 13,14,15,8..12.
    seq_v[0] = 8'd13; seq_v[1] = 8'd14; seq_v[2] = 8'd15; seq_v[3] = 8'd8;
    seq_v[4] = 8'd9;  seq_v[5] = 8'd10; seq_v[6] = 8'd11; seq_v[7] = 8'd12;
    for (int k = 0; k < 8; k++) dat_v[k] = {24'd0, seq_v[k]};
    run_burst(8, 2'b10, 1'b0, "wrap8 rd");

    // Wrap-16 read from word 30: 30,31,16..29.
    seq_v[0] = 8'd30; seq_v[1] = 8'd31;
    for (int k = 2; k < 16; k++) seq_v[k] = 8'(14 + k);
    for (int k = 0; k < 16; k++) dat_v[k] = {24'd0, seq_v[k]};
    run_burst(16, 2'b11, 1'b0, "wrap16 rd");

    // Out-of-range classic write at byte address 4*depth.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'd1024; dat_i = 32'hDEADBEEF;
    cti = 3'b000;
    @(negedge clk);
    check_eq("oor err0", {31'd0, err}, 32'd0);
    check_eq("oor we0", {28'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("oor err1", {31'd0, err}, 32'd1);
    check_eq("oor ack", {31'd0, ack}, 32'd0);
    check_eq("oor we1", {28'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check_eq("oor errend", {31'd0, err}, 32'd0);
    classic(32'd0, 1'b0, 4'hF, 32'd0, 32'd0, "oor mem0");

    // Reset during beat 2 of an 8-beat linear write burst at word 40.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; bte = 2'b00; cti = 3'b010;
    adr = 32'd160; dat_i = 32'hC0;
    @(negedge clk);
    check_eq("rb burst ack0", {31'd0, ack}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      adr = 32'(160 + 4 * k); dat_i = 32'(32'hC0 + k);
      @(negedge clk);
      check_eq($sformatf("rb burst ack b%0d", k), {31'd0, ack}, 32'd1);
      check_eq($sformatf("rb burst we b%0d", k), {28'd0, ram_we}, 32'hF);
    end
    @(posedge clk); #1;
    adr = 32'd168; dat_i = 32'hC2; rst = 1'b1;
    @(negedge clk);
    check_eq("rb rst we", {28'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    we = 1'b0; cti = 3'b000; adr = 32'd164;
    @(negedge clk);
    check_eq("rb post ack0", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rb post ack1", {31'd0, ack}, 32'd1);
    check_eq("rb post data", dat_o, 32'hC1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check_eq("rb post ackoff", {31'd0, ack}, 32'd0);
    classic(32'd168, 1'b0, 4'hF, 32'd0, 32'd42, "rb w42");
    classic(32'd160, 1'b0, 4'hF, 32'd0, 32'hC0, "rb w40");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
